// File: rtl/draw_sequencer.sv
// Control FSM for the 160x120 VGA pixel path: captures x then y/colour on keypresses and
// plots a square, or sweeps the whole screen clear; drives datapath strobes and plot.
module draw_sequencer #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int BLOCK_LOG2 = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    go,
    input  logic                    clear,
    output logic                    xEnable,
    output logic                    yEnable,
    output logic                    colourEnable,
    output logic                    controlReset,
    output logic                    countUp,
    output logic                    plot,
    output logic [2*BLOCK_LOG2-1:0] offset,
    output logic                    busy,
    output logic                    done
);

    // state         | meaning
    // S_LOAD_X      | idle, waiting for load (x) or clear
    // S_LOAD_X_WAIT | x latched, waiting for load release
    // S_LOAD_Y      | waiting for go (y, colour) or clear
    // S_LOAD_Y_WAIT | y/colour latched, waiting for go release
    // S_DRAW        | plotting the square, one pixel per cycle
    // S_CLEAR_INIT  | one-cycle datapath clear before the sweep
    // S_CLEAR       | plotting every screen pixel
    // S_DONE        | one-cycle completion pulse

    localparam int OFF_W   = 2 * BLOCK_LOG2;
    localparam int PIXELS  = WIDTH * HEIGHT;
    localparam int SWEEP_W = $clog2(PIXELS);
    localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(PIXELS - 1);
    localparam logic [OFF_W-1:0]   OFF_LAST   = '1;

    typedef enum logic [2:0] {
        S_LOAD_X,
        S_LOAD_X_WAIT,
        S_LOAD_Y,
        S_LOAD_Y_WAIT,
        S_DRAW,
        S_CLEAR_INIT,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t               state, state_next;
    logic [OFF_W-1:0]     offset_count;
    logic [SWEEP_W-1:0]   sweep_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_LOAD_X;
            offset_count <= '0;
            sweep_count  <= '0;
        end else begin
            state        <= state_next;
            // Both counters hold at zero outside their sweep, so entry always starts from 0.
            offset_count <= (state == S_DRAW)  ? offset_count + 1'b1 : '0;
            sweep_count  <= (state == S_CLEAR) ? sweep_count + 1'b1  : '0;
        end
    end

    always_comb begin
        state_next   = state;
        xEnable      = 1'b0;
        yEnable      = 1'b0;
        colourEnable = 1'b0;
        controlReset = 1'b0;
        countUp      = 1'b0;
        plot         = 1'b0;
        offset       = '0;
        busy         = 1'b0;
        done         = 1'b0;

        // Outputs are forced low while reset is held, even though state updates only at the edge.
        if (!reset) begin
            case (state)
                S_LOAD_X: begin
                    if (clear) begin
                        state_next = S_CLEAR_INIT;
                    end else if (load) begin
                        xEnable    = 1'b1;
                        state_next = S_LOAD_X_WAIT;
                    end
                end
                S_LOAD_X_WAIT: begin
                    if (!load) state_next = S_LOAD_Y;
                end
                S_LOAD_Y: begin
                    if (clear) begin
                        state_next = S_CLEAR_INIT;
                    end else if (go) begin
                        yEnable      = 1'b1;
                        colourEnable = 1'b1;
                        state_next   = S_LOAD_Y_WAIT;
                    end
                end
                S_LOAD_Y_WAIT: begin
                    if (!go) state_next = S_DRAW;
                end
                S_DRAW: begin
                    plot   = 1'b1;
                    busy   = 1'b1;
                    offset = offset_count;
                    if (offset_count == OFF_LAST) state_next = S_DONE;
                end
                S_CLEAR_INIT: begin
                    controlReset = 1'b1;
                    busy         = 1'b1;
                    state_next   = S_CLEAR;
                end
                S_CLEAR: begin
                    plot    = 1'b1;
                    countUp = 1'b1;
                    busy    = 1'b1;
                    if (sweep_count == SWEEP_LAST) state_next = S_DONE;
                end
                S_DONE: begin
                    done       = 1'b1;
                    state_next = S_LOAD_X;
                end
                default: state_next = S_LOAD_X;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Scoreboard bench for draw_sequencer: stimulus pushes the expected output cycles,
// a negedge monitor pops and compares every cycle on which the DUT shows any activity.
module tb_draw_sequencer;

    logic       clock = 1'b0;
    logic       reset, load, go, clear;
    logic       xEnable, yEnable, colourEnable, controlReset, countUp, plot, busy, done;
    logic [3:0] offset;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [11:0] vec;
    } exp_t;
    exp_t q[$];

    logic [11:0] vec_now;
    assign vec_now = {xEnable, yEnable, colourEnable, controlReset, countUp, plot, busy, done, offset};

    draw_sequencer #(.WIDTH(160), .HEIGHT(120), .BLOCK_LOG2(2)) dut (
        .clock(clock), .reset(reset), .load(load), .go(go), .clear(clear),
        .xEnable(xEnable), .yEnable(yEnable), .colourEnable(colourEnable),
        .controlReset(controlReset), .countUp(countUp), .plot(plot),
        .offset(offset), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [11:0] mk(input logic xe, input logic ye, input logic ce,
                                       input logic cr, input logic cu, input logic pl,
                                       input logic bz, input logic dn, input logic [3:0] off);
        return {xe, ye, ce, cr, cu, pl, bz, dn, off};
    endfunction

    task automatic push(input int c, input logic [11:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        q.push_back(e);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clock);
        checks++;
        if (vec_now !== 12'd0) begin
            errors++;
            $display("FAIL %s at cycle %0d: outputs %b, required all zero", name, cyc, vec_now);
        end
    endtask

    task automatic expect_sweep(input int first, input int count);
        for (int k = 0; k < count; k++) push(first + k, mk(0, 0, 0, 0, 1, 1, 1, 0, 4'd0));
    endtask

    // Monitor: every active cycle must match the next expected entry, cycle and values.
    always @(negedge clock) begin
        if (|vec_now[11:4]) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing output at cycle %0d: got nothing, required %b", q[0].cyc, q[0].vec);
                void'(q.pop_front());
            end
            checks++;
            if (q.size() == 0 || q[0].cyc > cyc) begin
                errors++;
                $display("FAIL unexpected output at cycle %0d: got %b, required none", cyc, vec_now);
            end else begin
                if (vec_now !== q[0].vec) begin
                    errors++;
                    $display("FAIL output value at cycle %0d: got %b, required %b", cyc, vec_now, q[0].vec);
                end
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t, d;
        reset = 1'b1; load = 1'b0; go = 1'b0; clear = 1'b0;
        step(2);
        load = 1'b1;
        check_idle("reset_outputs");
        step();
        reset = 1'b0; load = 1'b0;
        check_idle("post_reset_idle");

        // Draw: load 5 cycles, a stray load in S_LOAD_Y, go 3 cycles, keys during draw.
        step();
        load = 1'b1;
        push(cyc, mk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0));
        step(4);
        step();
        load = 1'b0;
        step();
        load = 1'b1;
        step();
        load = 1'b0; go = 1'b1;
        push(cyc, mk(0, 1, 1, 0, 0, 0, 0, 0, 4'd0));
        step(2);
        step();
        go = 1'b0;
        d = cyc + 1;
        for (int i = 0; i < 16; i++) push(d + i, mk(0, 0, 0, 0, 0, 1, 1, 0, 4'(i)));
        push(d + 16, mk(0, 0, 0, 0, 0, 0, 0, 1, 4'd0));
        step(3);
        load = 1'b1;
        step();
        load = 1'b0; go = 1'b1;
        step();
        go = 1'b0;
        step(20);
        check_idle("after_draw");

        // Full clear from a one-cycle pulse.
        step();
        clear = 1'b1;
        t = cyc;
        push(t + 1, mk(0, 0, 0, 1, 0, 0, 1, 0, 4'd0));
        expect_sweep(t + 2, 19200);
        push(t + 19202, mk(0, 0, 0, 0, 0, 0, 0, 1, 4'd0));
        step();
        clear = 1'b0;
        step(19205);
        check_idle("after_clear");

        // clear with load: no xEnable; reset lands when the sweep count is 5000.
        step();
        clear = 1'b1; load = 1'b1;
        t = cyc;
        push(t + 1, mk(0, 0, 0, 1, 0, 0, 1, 0, 4'd0));
        expect_sweep(t + 2, 5000);
        step();
        clear = 1'b0; load = 1'b0;
        step(5001);
        reset = 1'b1;
        check_idle("reset_mid_clear");
        step();
        check_idle("reset_held");
        step();
        reset = 1'b0;
        check_idle("after_mid_reset");

        // Load after reset, then clear with go in S_LOAD_Y: no yEnable, full sweep.
        step();
        load = 1'b1;
        push(cyc, mk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0));
        step();
        load = 1'b0;
        step();
        clear = 1'b1; go = 1'b1;
        t = cyc;
        push(t + 1, mk(0, 0, 0, 1, 0, 0, 1, 0, 4'd0));
        expect_sweep(t + 2, 19200);
        push(t + 19202, mk(0, 0, 0, 0, 0, 0, 0, 1, 4'd0));
        step();
        clear = 1'b0; go = 1'b0;
        step(19205);
        check_idle("final_idle");

        step(3);
        while (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL missing output at cycle %0d: got nothing, required %b", q[0].cyc, q[0].vec);
            void'(q.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
